// File: rtl/stage_reg_elastic.sv
// stage_reg_elastic
//   Elastic pipeline stage register with a valid/ready handshake. It carries
//   a WIDTH-bit payload between two core stages. With SKID=1 a two-entry skid
//   buffer is used, so inReady is a registered state bit. With SKID=0 a single
//   register is used, and its inReady looks at outReady combinationally.
//   flush squashes every held beat to a bubble. stallCount is a saturating
//   performance counter of back-pressured edges.
//
//   All state updates happen on the falling edge of clk, rst included.
//
// Ports
//   clk        clock (falling-edge active)
//   rst        synchronous active-high reset
//   inValid    upstream beat present
//   inReady    stage can accept a beat this cycle
//   inData     upstream payload
//   flush      synchronous kill of all held beats
//   outValid   downstream beat present
//   outReady   downstream consumes the beat this cycle
//   outData    payload; BUBBLE whenever outValid=0
//   stallCount saturating count of edges with outValid=1 and outReady=0
module stage_reg_elastic #(
    parameter int               WIDTH  = 32,
    parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}},
    parameter bit               SKID   = 1'b1,
    parameter int               CNTW   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] inData,
    input  logic             flush,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] outData,
    output logic [CNTW-1:0]  stallCount
);

    // The encoding is {mainValid, skidValid}. Each bit of the state is then
    // directly a flop. This keeps inReady registered in skid mode.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        TWO   = 2'b11
    } state_t;

    state_t           state_q, state_n;
    logic [WIDTH-1:0] main_q, skid_q;
    logic             accept, consume;
    logic             load_main, load_skid, main_from_skid;
    logic             main_valid, skid_valid;

    assign accept  = inValid & inReady;
    assign consume = outValid & outReady;

    // State register and datapath
    always_ff @(negedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            main_q     <= BUBBLE;
            skid_q     <= BUBBLE;
            stallCount <= '0;
        end else begin
            state_q <= state_n;
            if (flush) begin
                main_q <= BUBBLE;
                skid_q <= BUBBLE;
            end else begin
                if (load_main)
                    main_q <= inData;
                else if (main_from_skid)
                    main_q <= skid_q;
                if (load_skid)
                    skid_q <= inData;
            end
            // Counts on the flush edge too; the pre-edge outValid is used.
            if (outValid && !outReady && stallCount != {CNTW{1'b1}})
                stallCount <= stallCount + CNTW'(1);
        end
    end

    // Next-state logic
    always_comb begin
        state_n        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        if (SKID) begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_n   = ONE;
                        load_main = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        load_main = 1'b1;
                    end else if (accept) begin
                        // Downstream is stalled: park the new beat in the skid slot.
                        state_n   = TWO;
                        load_skid = 1'b1;
                    end else if (consume) begin
                        state_n = EMPTY;
                    end
                end
                TWO: begin
                    // inReady is low here, so only a drain is possible.
                    if (consume) begin
                        state_n        = ONE;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_n = EMPTY;
            endcase
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_n   = ONE;
                        load_main = 1'b1;
                    end
                end
                ONE: begin
                    if (accept)
                        load_main = 1'b1;
                    else if (consume)
                        state_n = EMPTY;
                end
                default: state_n = EMPTY;
            endcase
        end
        // Flush beats any transfer on the same edge. The payload registers
        // are reloaded with BUBBLE in the sequential block.
        if (flush)
            state_n = EMPTY;
    end

    // Output decode
    always_comb begin
        main_valid = state_q[1];
        skid_valid = state_q[0];
        outValid   = main_valid;
        outData    = main_valid ? main_q : BUBBLE;
        if (SKID)
            inReady = !skid_valid;
        else
            inReady = !main_valid | outReady;
    end

endmodule

// File: tb/tb_stage_reg_elastic.sv
module tb_stage_reg_elastic;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: skid mode, 32-bit payload, zero bubble
    logic        a_rst, a_iv, a_ir, a_fl, a_ov, a_or;
    logic [31:0] a_id, a_od;
    logic [15:0] a_sc;

    // DUT B: single-register mode, 8-bit payload, non-zero bubble, 2-bit counter
    logic        b_rst, b_iv, b_ir, b_fl, b_ov, b_or;
    logic [7:0]  b_id, b_od;
    logic [1:0]  b_sc;

    localparam logic [7:0] B_BUB = 8'h3C;

    stage_reg_elastic #(.WIDTH(32), .BUBBLE(32'h0), .SKID(1'b1), .CNTW(16)) dut_a (
        .clk(clk), .rst(a_rst), .inValid(a_iv), .inReady(a_ir), .inData(a_id),
        .flush(a_fl), .outValid(a_ov), .outReady(a_or), .outData(a_od), .stallCount(a_sc)
    );

    stage_reg_elastic #(.WIDTH(8), .BUBBLE(B_BUB), .SKID(1'b0), .CNTW(2)) dut_b (
        .clk(clk), .rst(b_rst), .inValid(b_iv), .inReady(b_ir), .inData(b_id),
        .flush(b_fl), .outValid(b_ov), .outReady(b_or), .outData(b_od), .stallCount(b_sc)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] qa[$];
    logic [7:0]  qb[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Inputs change just after the active (falling) edge.
    task automatic cyc;
        @(negedge clk);
        #1;
    endtask

    // Monitors sample on the rising edge, mid-cycle, when both inputs and
    // outputs are stable ahead of the falling edge that acts on them.
    always @(posedge clk) begin
        if (!a_rst) begin
            if (!a_ov) chk("a_bubble", a_od, 32'h0);
            if (a_ov && a_or && !a_fl) begin
                if (qa.size() == 0) chk("a_extra_beat", a_od, 64'hDEAD);
                else chk("a_data", a_od, qa.pop_front());
            end
        end
    end

    always @(posedge clk) begin
        if (!b_rst) begin
            if (!b_ov) chk("b_bubble", b_od, B_BUB);
            if (b_ov && b_or && !b_fl) begin
                if (qb.size() == 0) chk("b_extra_beat", b_od, 64'hDEAD);
                else chk("b_data", b_od, qb.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        a_rst = 1; a_iv = 1; a_id = 32'h12345678; a_fl = 0; a_or = 1;
        b_rst = 1; b_iv = 1; b_id = 8'h12;        b_fl = 0; b_or = 1;
        cyc; cyc;
        chk("a_rst_ov", a_ov, 0);
        chk("a_rst_od", a_od, 0);
        chk("a_rst_sc", a_sc, 0);
        chk("a_rst_ir", a_ir, 1);
        chk("b_rst_ov", b_ov, 0);
        chk("b_rst_od", b_od, B_BUB);
        chk("b_rst_sc", b_sc, 0);
        chk("b_rst_ir", b_ir, 1);
        b_iv = 0;

        // Streaming, one beat per cycle
        a_rst = 0; a_or = 1;
        for (int i = 1; i <= 4; i++) begin
            a_iv = 1; a_id = 32'(i);
            chk("a_stream_ir", a_ir, 1);
            qa.push_back(32'(i));
            cyc;
            chk("a_lat_ov", a_ov, 1);
            chk("a_lat_od", a_od, 64'(i));
        end
        a_iv = 0;
        cyc;
        chk("a_stream_empty", a_ov, 0);
        chk("a_stream_sc", a_sc, 0);

        // Backpressure into the skid buffer
        a_or = 0; a_iv = 1; a_id = 32'hA;
        chk("a_bp_ir0", a_ir, 1); qa.push_back(32'hA);
        cyc;
        a_id = 32'hB;
        chk("a_bp_ir1", a_ir, 1); qa.push_back(32'hB);
        cyc;
        chk("a_bp_ir_two", a_ir, 0);
        a_id = 32'hC;
        cyc;
        chk("a_bp_ir_hold", a_ir, 0);
        chk("a_bp_od_hold", a_od, 32'hA);
        cyc;
        chk("a_bp_sc", a_sc, 3);
        a_or = 1; a_iv = 0;
        cyc;
        chk("a_ir_return", a_ir, 1);
        chk("a_bp_od_b", a_od, 32'hB);
        a_iv = 1; a_id = 32'hC; qa.push_back(32'hC);
        cyc;
        chk("a_bp_od_c", a_od, 32'hC);
        a_iv = 0;
        cyc;
        chk("a_bp_drained", a_ov, 0);
        chk("a_bp_sc_after", a_sc, 3);

        // Flush while in TWO, with a beat offered on the flush edge
        a_or = 0; a_iv = 1; a_id = 32'h11; qa.push_back(32'h11);
        cyc;
        a_id = 32'h22; qa.push_back(32'h22);
        cyc;
        chk("a_fl_two_ir", a_ir, 0);
        a_fl = 1; a_id = 32'h33; a_or = 1;
        cyc;
        qa.delete();
        a_fl = 0; a_iv = 0;
        chk("a_fl_ov", a_ov, 0);
        chk("a_fl_od", a_od, 0);
        chk("a_fl_ir", a_ir, 1);
        chk("a_fl_sc", a_sc, 4);
        cyc;
        chk("a_fl_gone", a_ov, 0);

        // Accept on the flush edge is dropped
        a_iv = 1; a_id = 32'h44; a_fl = 1;
        cyc;
        a_fl = 0; a_iv = 0;
        chk("a_fl_acc_ov", a_ov, 0);
        cyc;
        chk("a_fl_acc_ov2", a_ov, 0);

        // A stall on the flush edge still counts
        a_or = 0; a_iv = 1; a_id = 32'h55; qa.push_back(32'h55);
        cyc;
        a_iv = 0; a_fl = 1;
        cyc;
        qa.delete();
        a_fl = 0; a_or = 1;
        chk("a_fl_stall_sc", a_sc, 5);
        chk("a_fl_stall_ov", a_ov, 0);

        // SKID=0: inReady follows outReady while full
        b_rst = 0; b_or = 1; b_iv = 1; b_id = 8'h01;
        chk("b_ir_empty", b_ir, 1); qb.push_back(8'h01);
        cyc;
        chk("b_od_1", b_od, 8'h01);
        b_or = 0; b_id = 8'h02; #1;
        chk("b_ir_mirror0", b_ir, 0);
        cyc;
        chk("b_od_hold", b_od, 8'h01);
        chk("b_sc_1", b_sc, 1);
        b_or = 1; #1;
        chk("b_ir_mirror1", b_ir, 1); qb.push_back(8'h02);
        cyc;
        chk("b_od_2", b_od, 8'h02);
        b_or = 0; #1;
        chk("b_ir_mirror2", b_ir, 0);
        cyc;
        b_or = 1; #1;
        chk("b_ir_mirror3", b_ir, 1);
        b_id = 8'h03; qb.push_back(8'h03);
        cyc;
        chk("b_od_3", b_od, 8'h03);
        b_iv = 0;
        cyc;
        chk("b_empty_ov", b_ov, 0);
        chk("b_empty_od", b_od, B_BUB);
        chk("b_sc_2", b_sc, 2);

        // Saturation with a 2-bit counter
        b_rst = 1;
        cyc;
        b_rst = 0;
        chk("b_sc_clr", b_sc, 0);
        b_iv = 1; b_id = 8'h77; b_or = 1; qb.push_back(8'h77);
        cyc;
        b_iv = 0; b_or = 0;
        for (int i = 0; i < 6; i++) begin
            cyc;
            chk("b_sat", b_sc, (i + 1 > 3) ? 3 : i + 1);
        end
        b_or = 1;
        cyc;
        chk("b_sat_drain", b_ov, 0);

        cyc;
        chk("a_queue_empty", qa.size(), 0);
        chk("b_queue_empty", qb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
